// File: rtl/fetch_stage_pkg.sv
// Shared constants and the {instr, pc} entry type for the fetch stage.
// Consumed by the fetch stage top and its testbench.
package fetch_stage_pkg;

  localparam int XLEN        = 32;
  localparam int INSTR_ALIGN = 2;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return pc & ~XLEN'((1 << INSTR_ALIGN) - 1);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush; head is combinational from storage, push-to-head is 1 cycle.
// A push at full is taken only together with a pop; flush overrides both push and pop.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_dat_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         head_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      // DEPTH is a power of two, so pointers wrap naturally
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= push_dat_i;
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, issues credit-limited imem requests, buffers {instr, pc} for decode.
// Response-to-id_valid is 1 cycle; requests stall once outstanding + buffered reaches FIFO_DEPTH.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [XLEN-1:0] pc_q, pc_d;
  logic [CW-1:0]   outstanding_q, outstanding_d;
  logic [CW-1:0]   drop_q, drop_d;
  logic            rst_q;

  fetch_entry_t    buf_head, buf_push_dat;
  logic            buf_empty, buf_full;
  logic [CW-1:0]   buf_count;
  logic [XLEN-1:0] inf_head;
  logic            inf_empty, inf_full;
  logic [CW-1:0]   inf_count;

  logic            req_fire, rsp_fire, keep_rsp, id_fire;
  logic [CW:0]     credits_used;
  logic            unused_fifo_status;

  assign credits_used   = {1'b0, outstanding_q} + {1'b0, buf_count};
  assign imem_req_valid = !rst_q && !redirect_valid && (credits_used < (CW+1)'(FIFO_DEPTH));
  assign imem_req_addr  = pc_q;

  assign req_fire = imem_req_valid && imem_req_ready;
  // A response with nothing outstanding is a protocol violation and is ignored
  assign rsp_fire = imem_rsp_valid && (outstanding_q != '0);
  assign keep_rsp = rsp_fire && (drop_q == '0);
  assign id_fire  = id_valid && id_ready;

  assign buf_push_dat = '{instr: imem_rsp_data, pc: inf_head};

  assign id_valid = !buf_empty;
  assign id_instr = buf_empty ? NOP_INSTR : buf_head.instr;
  assign id_pc    = buf_empty ? '0 : buf_head.pc;

  always_comb begin
    pc_d          = pc_q;
    outstanding_d = outstanding_q + CW'(req_fire) - CW'(rsp_fire);
    drop_d        = drop_q;
    if (rsp_fire && (drop_q != '0)) drop_d = drop_q - CW'(1);
    if (redirect_valid) begin
      pc_d   = align_pc(redirect_pc);
      // Everything still in flight after this edge belongs to the old path
      drop_d = outstanding_d;
    end else if (req_fire) begin
      pc_d = pc_q + 32'd4;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      outstanding_q <= '0;
      drop_q        <= '0;
      rst_q         <= 1'b1;
    end else begin
      pc_q          <= pc_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
      rst_q         <= 1'b0;
    end
  end

  fetch_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH($bits(fetch_entry_t))) u_ibuf (
    .clk        (clk),
    .rst        (rst),
    .flush_i    (redirect_valid),
    .push_i     (keep_rsp),
    .push_dat_i (buf_push_dat),
    .pop_i      (id_fire),
    .head_o     (buf_head),
    .full_o     (buf_full),
    .empty_o    (buf_empty),
    .count_o    (buf_count)
  );

  // In-flight PCs are never flushed; stale ones drain through the drop count
  fetch_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(XLEN)) u_inflight (
    .clk        (clk),
    .rst        (rst),
    .flush_i    (1'b0),
    .push_i     (req_fire),
    .push_dat_i (pc_q),
    .pop_i      (rsp_fire),
    .head_o     (inf_head),
    .full_o     (inf_full),
    .empty_o    (inf_empty),
    .count_o    (inf_count)
  );

  assign unused_fifo_status = buf_full ^ inf_full ^ inf_empty ^ (^inf_count);

  a_rsp_without_req: assert property (@(posedge clk) disable iff (rst)
    !(imem_rsp_valid && (outstanding_q == '0)));

endmodule
